// File: rtl/jelly3_axi4l_regfile_pkg.sv
// jelly3_axi4l_regfile_pkg
//  Shared types and helpers for the AXI4-Lite register-file responder:
//   resp_t          AXI response codes
//   calc_addr_lsb   byte-offset width of one data word
//   addr_to_index   word index of a byte address (address bits above the byte lane)
package jelly3_axi4l_regfile_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  function automatic int calc_addr_lsb(input int data_bits);
    return $clog2(data_bits / 8);
  endfunction

  // Returns every bit above the byte lane, so callers can detect both
  // idx >= NUM_REGS and stray high address bits with one compare.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr, input int addr_lsb);
    return addr >> addr_lsb;
  endfunction

endpackage

// File: rtl/jelly3_axi4l_regfile_if.sv
// jelly3_axi4l_regfile_if
//  AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//  master : initiator side (drives addresses, data, bready/rready)
//  slave  : responder side (drives readies, responses, read data)
interface jelly3_axi4l_regfile_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  localparam int STRB_BITS = DATA_BITS / 8;

  logic [ADDR_BITS-1:0] awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [ADDR_BITS-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/jelly3_axi4l_regfile_wjoin.sv
// jelly3_axi4l_regfile_wjoin
//  Joins the independent AW and W channels. Each channel is captured into
//  its own hold register in any order; when both are held and the B slot is
//  free, commit fires for one cycle and both holds clear.
//  Ports:
//   clk, reset          clock, synchronous active-high reset
//   awvalid/awaddr      AW channel in;  awready out (registered, = !aw_hold)
//   wvalid/wdata/wstrb  W channel in;   wready  out (registered, = !w_hold)
//   b_free              B slot can take a new response this cycle
//   commit              write commit strobe
//   aw_addr/w_data/w_strb  held address/data/strobes
module jelly3_axi4l_regfile_wjoin #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  localparam int STRB_BITS = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 awvalid,
  input  logic [ADDR_BITS-1:0] awaddr,
  output logic                 awready,
  input  logic                 wvalid,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [STRB_BITS-1:0] wstrb,
  output logic                 wready,
  input  logic                 b_free,
  output logic                 commit,
  output logic [ADDR_BITS-1:0] aw_addr,
  output logic [DATA_BITS-1:0] w_data,
  output logic [STRB_BITS-1:0] w_strb
);

  logic aw_hold, w_hold;
  logic aw_hold_next, w_hold_next;

  // Gated by reset so nothing commits in a reset cycle with stale holds.
  assign commit = aw_hold && w_hold && b_free && !reset;

  // Accept and commit are mutually exclusive per channel (accept needs the
  // hold empty, commit needs it full), so ordering here is not significant.
  always_comb begin
    aw_hold_next = aw_hold;
    w_hold_next  = w_hold;
    if (commit) begin
      aw_hold_next = 1'b0;
      w_hold_next  = 1'b0;
    end
    if (awvalid && awready) aw_hold_next = 1'b1;
    if (wvalid && wready)   w_hold_next  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b1;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      aw_hold <= aw_hold_next;
      w_hold  <= w_hold_next;
      awready <= !aw_hold_next;
      wready  <= !w_hold_next;
      if (awvalid && awready) aw_addr <= awaddr;
      if (wvalid && wready) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
    end
  end

endmodule

// File: rtl/jelly3_axi4l_regfile_responder.sv
// jelly3_axi4l_regfile_responder
//  AXI4-Lite responder holding NUM_REGS read/write words.
//  Ports:
//   clk, reset     clock, synchronous active-high reset
//   s_axi4l        AXI4-Lite slave bundle (prot fields ignored)
//   out_regs       current register values, reg i at [i*DATA_BITS +: DATA_BITS]
//   out_wr_pulse   one-cycle pulse on bit i in the commit cycle of reg i
//  Build option: JELLY3_AXI4L_REGFILE_DECERR_EN makes out-of-range accesses
//  answer DECERR; otherwise they answer OKAY. Out-of-range writes are dropped
//  and out-of-range reads return zero either way.
module jelly3_axi4l_regfile_responder
  import jelly3_axi4l_regfile_pkg::*;
#(
  parameter int                   ADDR_BITS  = 32,
  parameter int                   DATA_BITS  = 32,
  parameter int                   NUM_REGS   = 16,
  parameter logic [DATA_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  jelly3_axi4l_regfile_if.slave         s_axi4l,
  output logic [NUM_REGS*DATA_BITS-1:0] out_regs,
  output logic [NUM_REGS-1:0]           out_wr_pulse
);

  localparam int ADDR_LSB  = calc_addr_lsb(DATA_BITS);
  localparam int STRB_BITS = DATA_BITS / 8;
`ifdef JELLY3_AXI4L_REGFILE_DECERR_EN
  localparam resp_t OOR_RESP = DECERR;
`else
  localparam resp_t OOR_RESP = OKAY;
`endif

  logic [DATA_BITS-1:0] regs [NUM_REGS];

  logic                 commit;
  logic [ADDR_BITS-1:0] aw_addr;
  logic [DATA_BITS-1:0] w_data;
  logic [STRB_BITS-1:0] w_strb;

  jelly3_axi4l_regfile_wjoin #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_wjoin (
    .clk     (clk),
    .reset   (reset),
    .awvalid (s_axi4l.awvalid),
    .awaddr  (s_axi4l.awaddr),
    .awready (s_axi4l.awready),
    .wvalid  (s_axi4l.wvalid),
    .wdata   (s_axi4l.wdata),
    .wstrb   (s_axi4l.wstrb),
    .wready  (s_axi4l.wready),
    // A response leaving this cycle frees the slot for the next commit.
    .b_free  (!s_axi4l.bvalid || s_axi4l.bready),
    .commit  (commit),
    .aw_addr (aw_addr),
    .w_data  (w_data),
    .w_strb  (w_strb)
  );

  // Address decode: the full index (all bits above the byte lane) must be
  // below NUM_REGS, which also rejects stray high address bits.
  logic [63:0] aw_idx, ar_idx;
  logic        aw_ok, ar_ok;
  assign aw_idx = addr_to_index(64'(aw_addr), ADDR_LSB);
  assign ar_idx = addr_to_index(64'(s_axi4l.araddr), ADDR_LSB);
  assign aw_ok  = aw_idx < 64'(NUM_REGS);
  assign ar_ok  = ar_idx < 64'(NUM_REGS);

  logic [NUM_REGS-1:0] hit;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign hit[i] = commit && aw_ok && (aw_idx == 64'(i));
    assign out_regs[i*DATA_BITS +: DATA_BITS] = regs[i];
  end
  assign out_wr_pulse = hit;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs[i] <= INIT_VALUE;
      end else if (hit[i]) begin
        for (int b = 0; b < STRB_BITS; b++) begin
          if (w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

  logic [DATA_BITS-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == 64'(i)) rd_word = regs[i];
    end
  end

  // Read data is sampled from the pre-edge register value, so a read that
  // lands in a commit cycle returns the old contents.
  assign s_axi4l.arready = !s_axi4l.rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi4l.bvalid <= 1'b0;
      s_axi4l.bresp  <= OKAY;
      s_axi4l.rvalid <= 1'b0;
      s_axi4l.rdata  <= '0;
      s_axi4l.rresp  <= OKAY;
    end else begin
      if (commit) begin
        s_axi4l.bvalid <= 1'b1;
        s_axi4l.bresp  <= aw_ok ? OKAY : OOR_RESP;
      end else if (s_axi4l.bready) begin
        s_axi4l.bvalid <= 1'b0;
      end

      if (s_axi4l.arvalid && !s_axi4l.rvalid) begin
        s_axi4l.rvalid <= 1'b1;
        s_axi4l.rdata  <= ar_ok ? rd_word : '0;
        s_axi4l.rresp  <= ar_ok ? OKAY : OOR_RESP;
      end else if (s_axi4l.rready) begin
        s_axi4l.rvalid <= 1'b0;
      end
    end
  end

  wire unused_prot = &{1'b0, s_axi4l.awprot, s_axi4l.arprot};

endmodule
